board_io_ctrl: RTL and testbench
================================

Name: board_io_ctrl

Overview:
Board-level I/O front-end between raw FPGA pins and the Murax GPIO bank. It generalises direct GPIO-to-LED wiring to parametrised channel counts. Each button gets synchronisation, debouncing and press-event detection. Each LED gets a PWM brightness driver gated by a GPIO write bit. It sits in the board toplevel, in the PLL-generated main clock domain.

Parameters:
NUM_BUTTONS, 2, number of button input channels (1..32)
NUM_LEDS, 4, number of LED output channels (1..32)
DEBOUNCE_CYCLES, 12000, consecutive stable cycles needed to accept a button change (>=1; 1 ms at 12 MHz)
PWM_BITS, 8, PWM counter/duty width (1..16); period = 2^PWM_BITS cycles

Ports:
io_mainClk  input  1  system clock; all logic on rising edge
io_reset  input  1  synchronous, active-high reset
io_buttons_raw  input  NUM_BUTTONS  asynchronous raw button pins, active-high
io_buttons_level  output  NUM_BUTTONS  debounced button state
io_buttons_press  output  NUM_BUTTONS  one-cycle pulse on debounced 0->1
io_leds_enable  input  NUM_LEDS  per-LED enable (from GPIO write bits)
io_leds_duty  input  NUM_LEDS*PWM_BITS  per-LED duty; channel i at bits [i*PWM_BITS +: PWM_BITS]
io_leds_out  output  NUM_LEDS  PWM LED drive, registered

Behaviour:
- Reset (synchronous, io_reset=1 at an edge):
  - All sync flops, debounce counters, levels, press pulses, PWM counter, duty shadows and io_leds_out are set to 0.
  - Reset has priority over every other event.
- Synchroniser: two flops per button (sync1, sync2). Only sync2 feeds the debouncer.
- Debouncer, per channel: counter width = clog2(DEBOUNCE_CYCLES+1).
  - sync2 == level: counter <= 0.
  - sync2 != level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync2 != level and counter == DEBOUNCE_CYCLES-1: level <= sync2, counter <= 0.
  - Any glitch returning sync2 to level before acceptance restarts the count from 0.
- Latency: a raw change held stable updates io_buttons_level on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new value as edge 1.
- Press event: io_buttons_press[i] is high for exactly the one cycle in which level[i] first reads 1. A release (1->0) produces no press pulse. Channels are fully independent, so simultaneous presses give simultaneous pulses.
- Reset mid-operation: any partial count is discarded. A button held through reset release produces a press pulse DEBOUNCE_CYCLES+2 edges after reset deasserts.
- PWM counter: one shared free-running counter of PWM_BITS bits, wrapping from 2^PWM_BITS-1 to 0.
- Duty shadow: each channel's duty is captured into a shadow register on the edge where the counter wraps to 0. A duty change therefore takes effect at the next period boundary, never mid-period. Shadows reset to 0, so the first period after reset is dark.
- LED output: io_leds_out[i] <= enable[i] & ((cnt < shadow[i]) | (shadow[i] == all-ones)). This gives one cycle of latency from the counter.
  - duty 0: constantly off.
  - duty all-ones: constantly on, with no 1-cycle dropout.
  - Otherwise: high for duty cycles per 2^PWM_BITS.
- Enable path: io_leds_enable is not shadowed; deasserting it forces the output to 0 on the next edge.

Optional Feature:
BOARD_IO_RELEASE_EN
- Defined: adds output port io_buttons_release (NUM_BUTTONS). It pulses for one cycle, in the cycle in which level[i] first reads 0 after being 1. It resets to 0 and follows the same latency as press.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Clean press: DEBOUNCE_CYCLES=4; raw[0] 0->1 held -> level[0] rises on edge 6 with a single press[0] pulse that cycle; level[1] and press[1] stay 0.
- Bounce: DEBOUNCE_CYCLES=4; raw toggles 1,1,1,0,1,1,1,1 per cycle -> no acceptance until 4 consecutive stable sync2 cycles; exactly one press pulse.
- Reset mid-count: button held, io_reset pulsed at counter=2 -> level stays 0; press pulse 6 edges after reset deasserts.
- PWM duty: PWM_BITS=8, enable=1, duty=64 -> io_leds_out high for exactly 64 of every 256 cycles, contiguous from the period start (+1 cycle latency).
- Duty boundaries: duty=0 -> output always 0; duty=255 -> output always 1 across a full period; duty changed 64->128 mid-period -> current period keeps 64, next period gives 128.
- Enable/release: enable deasserted mid-high -> output 0 on the next edge. With BOARD_IO_RELEASE_EN: a button release gives one io_buttons_release pulse, DEBOUNCE_CYCLES+2 edges after raw falls.

Source files
------------

// File: rtl/board_io_ctrl.sv
// Board I/O front-end: button sync/debounce/press detection and per-LED PWM drive.
// Optional macro BOARD_IO_RELEASE_EN adds io_buttons_release (one-cycle pulse on debounced 1->0).
module board_io_ctrl #(
  parameter int NUM_BUTTONS     = 2,
  parameter int NUM_LEDS        = 4,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int PWM_BITS        = 8
) (
  input  logic                         io_mainClk,
  input  logic                         io_reset,
  input  logic [NUM_BUTTONS-1:0]       io_buttons_raw,
  output logic [NUM_BUTTONS-1:0]       io_buttons_level,
  output logic [NUM_BUTTONS-1:0]       io_buttons_press,
`ifdef BOARD_IO_RELEASE_EN
  output logic [NUM_BUTTONS-1:0]       io_buttons_release,
`endif
  input  logic [NUM_LEDS-1:0]          io_leds_enable,
  input  logic [NUM_LEDS*PWM_BITS-1:0] io_leds_duty,
  output logic [NUM_LEDS-1:0]          io_leds_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [NUM_BUTTONS-1:0] sync1;
  logic [NUM_BUTTONS-1:0] sync2;
  logic [CW-1:0]          db_cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] accept;

  // A channel accepts its new value when it has differed from level for the full count.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      accept[i] = (sync2[i] != io_buttons_level[i]) && (db_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      sync1            <= '0;
      sync2            <= '0;
      io_buttons_level <= '0;
      io_buttons_press <= '0;
`ifdef BOARD_IO_RELEASE_EN
      io_buttons_release <= '0;
`endif
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1            <= io_buttons_raw;
      sync2            <= sync1;
      io_buttons_level <= io_buttons_level ^ accept;
      // Pulses are registered alongside level so they coincide with the level edge.
      io_buttons_press <= accept & sync2;
`ifdef BOARD_IO_RELEASE_EN
      io_buttons_release <= accept & ~sync2;
`endif
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (sync2[i] == io_buttons_level[i] || accept[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] shadow [NUM_LEDS];
  logic                pwm_wrap;

  assign pwm_wrap = (pwm_cnt == PWM_MAX);

  // Duty is only sampled at the period boundary so a period never changes shape mid-way.
  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      pwm_cnt     <= '0;
      io_leds_out <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (pwm_wrap) begin
          shadow[i] <= io_leds_duty[i*PWM_BITS +: PWM_BITS];
        end
        io_leds_out[i] <= io_leds_enable[i] &
                          ((pwm_cnt < shadow[i]) | (shadow[i] == PWM_MAX));
      end
    end
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Bench for board_io_ctrl: vector table for the button path, closed-form PWM expectations.
module tb_board_io_ctrl;
  localparam int NB = 2;
  localparam int NL = 4;
  localparam int DB = 4;
  localparam int PB = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB-1:0]     raw;
  logic [NB-1:0]     level;
  logic [NB-1:0]     press;
  logic [NB-1:0]     rel;
  logic [NL-1:0]     en;
  logic [NL*PB-1:0]  duty;
  logic [NL-1:0]     leds;

`ifdef BOARD_IO_RELEASE_EN
  localparam logic [NB-1:0] REL_MASK = '1;
`else
  localparam logic [NB-1:0] REL_MASK = '0;
  assign rel = '0;
`endif

  board_io_ctrl #(
    .NUM_BUTTONS(NB), .NUM_LEDS(NL), .DEBOUNCE_CYCLES(DB), .PWM_BITS(PB)
  ) dut (
    .io_mainClk(clk),
    .io_reset(rst),
    .io_buttons_raw(raw),
    .io_buttons_level(level),
    .io_buttons_press(press),
`ifdef BOARD_IO_RELEASE_EN
    .io_buttons_release(rel),
`endif
    .io_leds_enable(en),
    .io_leds_duty(duty),
    .io_leds_out(leds)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NB-1:0] raw;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         passed = 0;

  task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s[%0d] got %h expected %h", name, idx, got, exp);
  endtask

  function automatic void add(input int n, input logic r, input logic [NB-1:0] rw,
                              input logic [NB-1:0] lv, input logic [NB-1:0] pr,
                              input logic [NB-1:0] rl);
    vec_t v;
    v.rst = r; v.raw = rw; v.level = lv; v.press = pr; v.rel = rl;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  function automatic logic led_exp(input logic e, input int j, input int d);
    return e && ((j < d) || (d == 255));
  endfunction

  // driver: apply inputs, push expectation, one edge, compare on the falling edge
  task automatic tick_cmp(input string name, input int idx, input logic [7:0] got_sel);
    logic [7:0] e;
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    if (got_sel) check(name, idx, {level, press, rel & REL_MASK}, e);
    else         check(name, idx, {4'b0, leds}, e);
  endtask

  initial begin
    int hi0;
    int hi2;
    rst = 1'b1; raw = '0; en = '0; duty = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_btn", 0, {level, press, rel}, 8'h00);
    check("reset_led", 0, {4'b0, leds}, 8'h00);
    rst = 1'b0;

    // clean press on button 0
    add(5, 0, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 0, 2'b01, 2'b01, 2'b01, 2'b00);
    add(2, 0, 2'b01, 2'b01, 2'b00, 2'b00);
    // bounce on button 1: 1,1,1,0 then stable 1
    add(3, 0, 2'b11, 2'b01, 2'b00, 2'b00);
    add(1, 0, 2'b01, 2'b01, 2'b00, 2'b00);
    add(5, 0, 2'b11, 2'b01, 2'b00, 2'b00);
    add(1, 0, 2'b11, 2'b11, 2'b10, 2'b00);
    add(1, 0, 2'b11, 2'b11, 2'b00, 2'b00);
    // release button 0: no press, release pulse if enabled
    add(5, 0, 2'b10, 2'b11, 2'b00, 2'b00);
    add(1, 0, 2'b10, 2'b10, 2'b00, 2'b01);
    add(1, 0, 2'b10, 2'b10, 2'b00, 2'b00);
    // reset mid-count with button held
    add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(4, 0, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(5, 0, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 0, 2'b01, 2'b01, 2'b01, 2'b00);
    add(1, 0, 2'b01, 2'b01, 2'b00, 2'b00);
    // simultaneous presses
    add(1, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(5, 0, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 0, 2'b11, 2'b11, 2'b11, 2'b00);
    add(1, 0, 2'b11, 2'b11, 2'b00, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      raw = vecs[i].raw;
      exp_q.push_back({2'b00, vecs[i].level, vecs[i].press, vecs[i].rel & REL_MASK});
      tick_cmp("btn", i, 1'b1);
    end

    // PWM: reset aligns the counter; period 0 is dark, duties land at period 1
    rst = 1'b1; raw = '0;
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    en   = 4'b1111;
    duty = {8'd128, 8'd255, 8'd0, 8'd64};
    hi0 = 0; hi2 = 0;
    for (int k = 1; k <= 768; k++) begin
      int p, j, d0, d2, d3;
      p = (k - 1) / 256;
      j = (k - 1) % 256;
      if (k == 357) duty[7:0] = 8'd128;   // mid-period change, seen from period 2
      if (k == 523) en[0] = 1'b0;         // drop enable while led 0 is high
      if (k == 563) en[0] = 1'b1;
      d0 = (p == 0) ? 0 : (p == 1) ? 64 : 128;
      d2 = (p == 0) ? 0 : 255;
      d3 = (p == 0) ? 0 : 128;
      exp_q.push_back({4'b0, led_exp(en[3], j, d3), led_exp(en[2], j, d2),
                       led_exp(en[1], j, 0), led_exp(en[0], j, d0)});
      tick_cmp("pwm", k, 1'b0);
      if (p == 1) begin
        hi0 += int'(leds[0]);
        hi2 += int'(leds[2]);
      end
    end
    check("pwm_count64", 0, hi0[7:0], 8'd64);
    check("pwm_count255", 0, {7'b0, hi2 == 256}, 8'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
